// File: rtl/lfsr10_source_if.sv
// Bus bundle for the LFSR operand source: run/seed controls in, random value
// and its strobes out. The comparator side drives controls (master).
interface lfsr10_source_if;
    logic       en;
    logic       load;
    logic [9:0] seed;
    logic [9:0] Q;
    logic       valid;
    logic       period_done;

    modport master (
        output en,
        output load,
        output seed,
        input  Q,
        input  valid,
        input  period_done
    );

    modport slave (
        input  en,
        input  load,
        input  seed,
        output Q,
        output valid,
        output period_done
    );
endinterface

// File: rtl/lfsr10_source.sv
// Maximal-length 10-bit XNOR LFSR (taps 10,7) feeding comparator operand B,
// with seed load, run enable, step-rate divider, new-value and full-period strobes.
module lfsr10_source #(
    parameter int         DIV        = 4,
    parameter logic [9:0] SEED_RESET = 10'h000
) (
    input logic             Clock,
    input logic             Reset,
    lfsr10_source_if.slave  bus
);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] div_cnt;
    logic [9:0] step_cnt;
    logic [9:0] q_reg;
    logic       valid_reg;
    logic       period_reg;
    logic       div_wrap;
    logic       feedback;

    // The datapath follows next_state so a rising en advances in the very same cycle.
    always_comb begin
        next_state = state;
        case (state)
            HOLD: if (bus.en)  next_state = RUN;
            RUN:  if (!bus.en) next_state = HOLD;
        endcase
        div_wrap = (div_cnt == DIV_LAST);
        feedback = ~(q_reg[9] ^ q_reg[6]);
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= HOLD;
        else       state <= next_state;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_reg      <= SEED_RESET;
            div_cnt    <= 4'd0;
            step_cnt   <= 10'd0;
            valid_reg  <= 1'b0;
            period_reg <= 1'b0;
        end else if (bus.load) begin
            // All-ones is the XNOR lockup state, so it is replaced by zero.
            q_reg      <= (bus.seed == 10'h3FF) ? 10'h000 : bus.seed;
            div_cnt    <= 4'd0;
            step_cnt   <= 10'd0;
            valid_reg  <= 1'b1;
            period_reg <= 1'b0;
        end else begin
            valid_reg  <= 1'b0;
            period_reg <= 1'b0;
            if (next_state == RUN) begin
                if (div_wrap) begin
                    div_cnt   <= 4'd0;
                    q_reg     <= {q_reg[8:0], feedback};
                    valid_reg <= 1'b1;
                    if (step_cnt == 10'd1022) begin
                        step_cnt   <= 10'd0;
                        period_reg <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt + 10'd1;
                    end
                end else begin
                    div_cnt <= div_cnt + 4'd1;
                end
            end
        end
    end

    assign bus.Q           = q_reg;
    assign bus.valid       = valid_reg;
    assign bus.period_done = period_reg;

endmodule
